// File: rtl/gpio_input_ctrl_if.sv
// Board-pin and core-status bundle for gpio_input_ctrl.
// The slave modport is the control block; the master modport is the board/core side.
interface gpio_input_ctrl_if #(
  parameter int NUM_CORES = 4,
  parameter int NUM_SW    = 4
);
  logic                 btn_start_i;
  logic                 btn_abort_i;
  logic [NUM_SW-1:0]    sw_i;
  logic [NUM_CORES-1:0] core_done_i;
  logic [NUM_SW-1:0]    sw_o;
  logic [NUM_SW-1:0]    sw_rise_o;
  logic [NUM_SW-1:0]    sw_fall_o;
  logic                 core_start_o;
  logic                 core_abort_o;
  logic                 busy_o;
  logic                 all_done_o;
  logic [NUM_CORES-1:0] done_mask_o;
  logic                 timeout_o;

  modport slave (
    input  btn_start_i, btn_abort_i, sw_i, core_done_i,
    output sw_o, sw_rise_o, sw_fall_o, core_start_o, core_abort_o,
           busy_o, all_done_o, done_mask_o, timeout_o
  );

  modport master (
    output btn_start_i, btn_abort_i, sw_i, core_done_i,
    input  sw_o, sw_rise_o, sw_fall_o, core_start_o, core_abort_o,
           busy_o, all_done_o, done_mask_o, timeout_o
  );
endinterface

// File: rtl/gpio_input_ctrl.sv
// GPIO input side: sync + debounce + edge detect for buttons/switches, and the core run FSM.
// Optional RUN watchdog built only when GPIO_TIMEOUT_EN is defined.
module gpio_input_ctrl #(
  parameter int NUM_CORES       = 4,
  parameter int NUM_SW          = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                clk,
  input  logic                rst,
  gpio_input_ctrl_if.slave    io
);

  localparam int N_IN      = NUM_SW + 2;
  localparam int IDX_START = NUM_SW;
  localparam int IDX_ABORT = NUM_SW + 1;
  localparam int CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("gpio_input_ctrl: DEBOUNCE_CYCLES and TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_RUN, S_ABORT, S_DONE} state_t;

  logic [N_IN-1:0]      raw;
  logic [N_IN-1:0]      sync_p0;
  logic [N_IN-1:0]      sync_p1;
  logic [N_IN-1:0]      stable_p2;
  logic [N_IN-1:0]      rise_p2;
  logic [NUM_SW-1:0]    fall_p2;
  logic [CNT_W-1:0]     cnt [N_IN];
  logic [N_IN-1:0]      diff;
  logic [N_IN-1:0]      accept;
  state_t               state, state_nxt;
  logic [NUM_CORES-1:0] done_mask;
  logic                 start_rise;
  logic                 abort_rise;
  logic                 all_set;
  logic                 timeout_hit;

  assign raw = {io.btn_abort_i, io.btn_start_i, io.sw_i};

  // stage p0/p1: two-flop synchroniser for every asynchronous pin
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // A bit is accepted once it has differed from the stable value for DEBOUNCE_CYCLES cycles.
  always_comb begin
    diff   = sync_p1 ^ stable_p2;
    accept = '0;
    for (int i = 0; i < N_IN; i++) begin
      accept[i] = diff[i] && (cnt[i] == CNT_MAX);
    end
  end

  // stage p2: debounced level plus edge pulses registered on the accepting edge
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_p2 <= '0;
      rise_p2   <= '0;
      fall_p2   <= '0;
      for (int i = 0; i < N_IN; i++) cnt[i] <= '0;
    end else begin
      stable_p2 <= (stable_p2 & ~accept) | (sync_p1 & accept);
      rise_p2   <= accept & sync_p1;
      fall_p2   <= accept[NUM_SW-1:0] & ~sync_p1[NUM_SW-1:0];
      for (int i = 0; i < N_IN; i++) begin
        if (!diff[i] || accept[i]) cnt[i] <= '0;
        else                       cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  assign start_rise = rise_p2[IDX_START];
  assign abort_rise = rise_p2[IDX_ABORT];
  assign all_set    = &(done_mask | io.core_done_i);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Abort wins over completion and timeout; completion wins over a coincident timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_rise && !abort_rise) state_nxt = S_START;
      S_START: state_nxt = abort_rise ? S_ABORT : S_RUN;
      S_RUN: begin
        if (abort_rise)       state_nxt = S_ABORT;
        else if (all_set)     state_nxt = S_DONE;
        else if (timeout_hit) state_nxt = S_ABORT;
      end
      S_ABORT: state_nxt = S_IDLE;
      S_DONE: begin
        if (abort_rise)      state_nxt = S_ABORT;
        else if (start_rise) state_nxt = S_START;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                 done_mask <= '0;
    else if (state == S_START) done_mask <= '0;
    else if (state == S_RUN)   done_mask <= done_mask | io.core_done_i;
  end

`ifdef GPIO_TIMEOUT_EN
  logic [31:0] timer;
  logic        timeout_q;

  // Fires in the RUN cycle where the incremented count would reach TIMEOUT_CYCLES.
  assign timeout_hit = (state == S_RUN) && (timer == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst)                   timer <= '0;
    else if (state == S_START) timer <= '0;
    else if (state == S_RUN)   timer <= timer + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst)                   timeout_q <= 1'b0;
    else if (state == S_START) timeout_q <= 1'b0;
    else if (timeout_hit && !abort_rise && !all_set) timeout_q <= 1'b1;
  end

  assign io.timeout_o = timeout_q;
`else
  assign timeout_hit  = 1'b0;
  assign io.timeout_o = 1'b0;
`endif

  assign io.sw_o         = stable_p2[NUM_SW-1:0];
  assign io.sw_rise_o    = rise_p2[NUM_SW-1:0];
  assign io.sw_fall_o    = fall_p2;
  assign io.core_start_o = (state == S_START);
  assign io.core_abort_o = (state == S_ABORT);
  assign io.busy_o       = (state == S_START) || (state == S_RUN);
  assign io.all_done_o   = (state == S_DONE);
  assign io.done_mask_o  = done_mask;

endmodule

// File: tb/tb_gpio_input_ctrl.sv
// Self-checking bench for gpio_input_ctrl: switch vectors via a scoreboard, FSM corner sequences.
module tb_gpio_input_ctrl;
  localparam int NC = 4;
  localparam int NS = 4;
  localparam int DB = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gpio_input_ctrl_if #(.NUM_CORES(NC), .NUM_SW(NS)) bus ();

  gpio_input_ctrl #(
    .NUM_CORES(NC), .NUM_SW(NS), .DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int       due;
    logic [3:0] sw;
    logic [3:0] rise;
    logic [3:0] fall;
  } sb_t;

  typedef struct {
    logic [3:0] sw_in;
    logic [3:0] exp_sw;
    logic [3:0] exp_rise;
    logic [3:0] exp_fall;
  } vec_t;

  sb_t  sb[$];
  sb_t  cur;
  vec_t tbl[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int due, input logic [3:0] sw, input logic [3:0] rise,
                      input logic [3:0] fall);
    sb_t e;
    e.due = due; e.sw = sw; e.rise = rise; e.fall = fall;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      cur = sb.pop_front();
      checks++;
      if (cur.due != cyc || bus.sw_o !== cur.sw || bus.sw_rise_o !== cur.rise ||
          bus.sw_fall_o !== cur.fall) begin
        errors++;
        $display("FAIL sw_sb due=%0d cyc=%0d: got sw=%b rise=%b fall=%b expected sw=%b rise=%b fall=%b",
                 cur.due, cyc, bus.sw_o, bus.sw_rise_o, bus.sw_fall_o, cur.sw, cur.rise, cur.fall);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c, n_st, n_ab, at;
    logic [3:0] prev;

    tbl[0] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000};
    tbl[1] = '{4'b0101, 4'b0101, 4'b0100, 4'b0000};
    tbl[2] = '{4'b0100, 4'b0100, 4'b0000, 4'b0001};
    tbl[3] = '{4'b1011, 4'b1011, 4'b1011, 4'b0100};
    tbl[4] = '{4'b0000, 4'b0000, 4'b0000, 4'b1011};

    rst = 1'b1;
    bus.btn_start_i = 1'b0;
    bus.btn_abort_i = 1'b0;
    bus.sw_i        = '0;
    bus.core_done_i = '0;
    repeat (3) step();
    chk("rst_sw",      {28'd0, bus.sw_o}, 0);
    chk("rst_ctrl",    {27'd0, bus.core_start_o, bus.core_abort_o, bus.busy_o,
                        bus.all_done_o, bus.timeout_o}, 0);
    chk("rst_mask",    {28'd0, bus.done_mask_o}, 0);
    rst = 1'b0;
    step();

    // switch vectors: old value 5 clocks after the change, new value + pulse at 6, pulse gone at 7
    prev = 4'b0000;
    for (int r = 0; r < 5; r++) begin
      bus.sw_i = tbl[r].sw_in;
      c = cyc;
      push(c + 5, prev, 4'b0000, 4'b0000);
      push(c + 6, tbl[r].exp_sw, tbl[r].exp_rise, tbl[r].exp_fall);
      push(c + 7, tbl[r].exp_sw, 4'b0000, 4'b0000);
      prev = tbl[r].exp_sw;
      repeat (8) step();
    end

    // 3-cycle glitch on sw[1] must never reach the outputs
    c = cyc;
    for (int k = 0; k < 10; k++) push(c + k, 4'b0000, 4'b0000, 4'b0000);
    bus.sw_i = 4'b0010;
    repeat (3) step();
    bus.sw_i = 4'b0000;
    repeat (10) step();
    chk("sb_drain", sb.size(), 0);

    // run to completion from IDLE
    bus.btn_start_i = 1'b1;
    n_st = 0; at = -1;
    for (int j = 1; j <= 9; j++) begin
      step();
      if (bus.core_start_o) begin n_st++; if (at < 0) at = j; end
      if (j == 6) begin chk("busy_before_start", bus.busy_o, 0); bus.btn_start_i = 1'b0; end
      if (j == 7) chk("busy_at_start", bus.busy_o, 1);
    end
    chk("start_count", n_st, 1);
    chk("start_latency", at, 7);
    chk("mask_run0", bus.done_mask_o, 4'b0000);
    bus.core_done_i = 4'b0001; step(); bus.core_done_i = 4'b0000;
    chk("mask_0001", bus.done_mask_o, 4'b0001);
    bus.core_done_i = 4'b0100; step(); bus.core_done_i = 4'b0000;
    chk("mask_0101", bus.done_mask_o, 4'b0101);
    chk("not_done_yet", bus.all_done_o, 0);
    bus.core_done_i = 4'b1010; step(); bus.core_done_i = 4'b0000;
    chk("mask_1111", bus.done_mask_o, 4'b1111);
    chk("all_done", bus.all_done_o, 1);
    chk("busy_done", bus.busy_o, 0);
    step();
    chk("done_hold", {bus.all_done_o, bus.done_mask_o}, 5'b11111);
    chk("timeout_idle", bus.timeout_o, 0);
    repeat (8) step();

    // restart from DONE, then abort in RUN with mask 0011
    bus.btn_start_i = 1'b1;
    n_st = 0; n_ab = 0; at = -1;
    for (int j = 1; j <= 14; j++) begin
      step();
      if (bus.core_start_o) n_st++;
      if (bus.core_abort_o) begin n_ab++; if (at < 0) at = j; end
      if (j == 3) bus.btn_abort_i = 1'b1;
      if (j == 6) bus.btn_start_i = 1'b0;
      if (j == 8) begin
        chk("mask_cleared", bus.done_mask_o, 4'b0000);
        chk("busy_run", bus.busy_o, 1);
        bus.core_done_i = 4'b0011;
      end
      if (j == 9) begin
        bus.core_done_i = 4'b0000;
        bus.btn_abort_i = 1'b0;
        chk("mask_0011", bus.done_mask_o, 4'b0011);
      end
      if (j == 11) begin
        chk("busy_after_abort", bus.busy_o, 0);
        chk("mask_held_abort", bus.done_mask_o, 4'b0011);
        chk("no_done_abort", bus.all_done_o, 0);
      end
    end
    chk("restart_count", n_st, 1);
    chk("abort_count", n_ab, 1);
    chk("abort_latency", at, 10);
    repeat (8) step();

    // start and abort together in IDLE: nothing happens
    bus.btn_start_i = 1'b1;
    bus.btn_abort_i = 1'b1;
    n_st = 0; n_ab = 0;
    for (int j = 1; j <= 12; j++) begin
      step();
      if (bus.core_start_o) n_st++;
      if (bus.core_abort_o) n_ab++;
      if (j == 8) begin bus.btn_start_i = 1'b0; bus.btn_abort_i = 1'b0; end
    end
    chk("idle_both_start", n_st, 0);
    chk("idle_both_abort", n_ab, 0);
    chk("idle_both_busy", bus.busy_o, 0);
    chk("idle_mask_held", bus.done_mask_o, 4'b0011);
    repeat (8) step();

    // synchronous reset in the middle of RUN
    bus.btn_start_i = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      step();
      if (j == 6) bus.btn_start_i = 1'b0;
      if (j == 8) bus.core_done_i = 4'b0001;
      if (j == 9) bus.core_done_i = 4'b0000;
    end
    chk("pre_rst_mask", bus.done_mask_o, 4'b0001);
    chk("pre_rst_busy", bus.busy_o, 1);
    rst = 1'b1;
    step();
    chk("midrst_ctrl", {27'd0, bus.core_start_o, bus.core_abort_o, bus.busy_o,
                        bus.all_done_o, bus.timeout_o}, 0);
    chk("midrst_mask", bus.done_mask_o, 4'b0000);
    rst = 1'b0;
    n_ab = 0;
    for (int j = 1; j <= 12; j++) begin
      step();
      if (bus.core_abort_o) n_ab++;
    end
    chk("midrst_no_abort", n_ab, 0);
    chk("midrst_idle", bus.busy_o, 0);
    repeat (4) step();

    // RUN with no done flags: watchdog when built in, otherwise waits indefinitely
    bus.btn_start_i = 1'b1;
    n_ab = 0; at = -1;
    for (int j = 1; j <= 30; j++) begin
      step();
      if (j == 6) bus.btn_start_i = 1'b0;
      if (bus.core_abort_o) begin n_ab++; if (at < 0) at = j; end
    end
`ifdef GPIO_TIMEOUT_EN
    chk("to_abort_count", n_ab, 1);
    chk("to_abort_cycle", at, 16);
    chk("to_flag", bus.timeout_o, 1);
    chk("to_idle", bus.busy_o, 0);
    repeat (4) step();
    bus.btn_start_i = 1'b1;
    for (int j = 1; j <= 9; j++) begin
      step();
      if (j == 6) begin chk("to_flag_held", bus.timeout_o, 1); bus.btn_start_i = 1'b0; end
      if (j == 8) chk("to_flag_cleared", bus.timeout_o, 0);
    end
`else
    chk("noto_abort_count", n_ab, 0);
    chk("noto_still_busy", bus.busy_o, 1);
    chk("noto_flag", bus.timeout_o, 0);
`endif
    bus.btn_abort_i = 1'b1;
    n_ab = 0;
    for (int j = 1; j <= 12; j++) begin
      step();
      if (bus.core_abort_o) n_ab++;
      if (j == 7) bus.btn_abort_i = 1'b0;
    end
    chk("final_abort_count", n_ab, 1);
    chk("final_idle", bus.busy_o, 0);

    repeat (2) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
